fc_sequencer: RTL and testbench
===============================

# fc_sequencer

Controller for the 10-output fully connected layer, the final classifier stage. It streams N_IN input features and their matching 10-wide weight words from synchronous buffers into the FC layer, then waits for the layer's finish pulse. It captures the ten 18-bit results and runs a sequential signed argmax. It reports the winning class index and its score with a one-cycle valid pulse, and flags a timeout if the FC layer never finishes.

## Interface
Parameters:
- N_IN, 84: number of input features per pass (1..2^ADDR_W).
- ADDR_W, 7: feature/weight buffer address width.
- TIMEOUT, 64: maximum cycles waited for fc_finish.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and zeroes every output.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- buf_rd  out  1  read enable to feature buffer and weight ROM.
- buf_addr  out  ADDR_W  shared read address.
- feat_data  in  16  signed feature; valid one cycle after buf_rd.
- weight_data  in  160  ten 16-bit weights; valid one cycle after buf_rd.
- fc_din  out  16  combinational copy of feat_data.
- fc_weight  out  160  combinational copy of weight_data.
- fc_ena  out  1  registered; buf_rd delayed one cycle.
- fc_finish  in  1  FC layer done pulse.
- fc_dout  in  180  ten signed 18-bit results; result[0] in [179:162] … result[9] in [17:0].
- class_valid  out  1  one-cycle pulse when the result is ready.
- class_id  out  4  argmax index 0..9; held until the next class_valid.
- class_score  out  18  signed winning value; held until the next class_valid.
- error  out  1  sticky timeout flag; cleared on the next accepted start.

## Operation
- States: IDLE, FETCH, DRAIN, WAIT_FIN, ARGMAX, DONE.
- IDLE: start=1 → FETCH, clear error, addr counter = 0.
- FETCH: buf_rd=1, buf_addr = counter, counter += 1.
  - After address N_IN-1 is issued → DRAIN.
- DRAIN: one cycle with buf_rd=0. fc_ena is still high for the last feature. → WAIT_FIN.
- WAIT_FIN: timeout counter increments each cycle.
  - fc_finish=1 → latch all ten results from fc_dout into the result register, best_idx=0, best=result[0], i=1 → ARGMAX.
  - Counter reaches TIMEOUT → error=1, → IDLE; no class_valid.
- fc_finish is also accepted in DRAIN, with the same action. It is ignored in every other state.
- ARGMAX: one comparison per cycle, i = 1..9.
  - If result[i] > best (signed, strict), then best=result[i] and best_idx=i.
  - Ties keep the lower index.
  - After i=9 → DONE.
- DONE: class_valid=1; class_id=best_idx and class_score=best registered this cycle; → IDLE.
- start outside IDLE: ignored and not queued.
- Reset mid-pass: immediate return to IDLE. buf_rd, fc_ena, busy, class_valid, error, class_id and class_score all go to 0. No partial result is reported.
- Counters: addr counter ADDR_W bits, no wrap within a pass. Timeout counter must be wide enough for TIMEOUT.

## Timing
- Reset values: every output 0; state IDLE.
- start sampled high at edge 0:
  - buf_rd=1 with buf_addr=k during cycles 1..N_IN, for k = 0..N_IN-1.
  - fc_ena=1 during cycles 2..N_IN+1, exactly N_IN contiguous cycles.
  - fc_din/fc_weight during those cycles carry the data for address k = cycle-2.
- DRAIN is cycle N_IN+1. WAIT_FIN starts at cycle N_IN+2.
- fc_finish sampled at cycle F:
  - ARGMAX occupies cycles F+1..F+9.
  - class_valid is high in cycle F+10.
  - busy=0 from F+11.
- Minimum pass length (finish in DRAIN): N_IN+11 cycles from start to class_valid.
- Timeout: error rises exactly TIMEOUT cycles after WAIT_FIN entry; busy falls the same cycle.
- A new start is accepted in the cycle busy is low. Back-to-back passes have one idle cycle between them.

## Test plan
- N_IN=84, fc_finish asserted 3 cycles after fc_ena falls, results {5,-3,200,7,200,0,-1,9,10,199} → class_id=2, class_score=200, class_valid exactly one cycle, fc_ena high exactly 84 cycles, addresses 0..83 in order.
- All results negative {-10,-4,-4,-100,…,-50} → class_id=1, class_score=-4. Checks signed compare and the tie rule.
- fc_finish never asserted → error=1 at WAIT_FIN entry +64 cycles, no class_valid, busy=0. Next start clears error.
- start pulsed again mid-FETCH and during ARGMAX → ignored; address sequence and result unchanged.
- reset asserted at address 40 → all outputs 0 asynchronously; a later start runs a full clean pass from address 0.
- fc_finish during DRAIN with max value at index 9 (result[9]=131071) → class_id=9, class_valid at cycle N_IN+11 after start.

Source files
------------

// File: rtl/fc_sequencer_if.sv
// fc_sequencer_if: buffer, FC-layer and classifier-result signals of the sequencer.
interface fc_sequencer_if #(parameter int ADDR_W = 7);
  logic              start;
  logic              busy;
  logic              buf_rd;
  logic [ADDR_W-1:0] buf_addr;
  logic [15:0]       feat_data;
  logic [159:0]      weight_data;
  logic [15:0]       fc_din;
  logic [159:0]      fc_weight;
  logic              fc_ena;
  logic              fc_finish;
  logic [179:0]      fc_dout;
  logic              class_valid;
  logic [3:0]        class_id;
  logic [17:0]       class_score;
  logic              error;
  modport master (
    input  start, feat_data, weight_data, fc_finish, fc_dout,
    output busy, buf_rd, buf_addr, fc_din, fc_weight, fc_ena,
           class_valid, class_id, class_score, error
  );
  modport slave (
    output start, feat_data, weight_data, fc_finish, fc_dout,
    input  busy, buf_rd, buf_addr, fc_din, fc_weight, fc_ena,
           class_valid, class_id, class_score, error
  );
endinterface

// File: rtl/fc_sequencer.sv
// fc_sequencer: streams features/weights into the 10-output FC layer, then picks the signed argmax class.
module fc_sequencer #(
  parameter int N_IN    = 84,
  parameter int ADDR_W  = 7,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  fc_sequencer_if.master bus
);
  localparam int T_W = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WAIT_FIN, ARGMAX, DONE} state_t;
  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  addr;
  logic [T_W-1:0]     tcnt;
  logic [3:0]         idx, best_idx, cand_idx, id_q;
  logic signed [17:0] res [10];
  logic signed [17:0] best, cand, score_q;
  logic               rd, ena_q, err_q, last_addr, timed_out, fin_ok, take;
  assign last_addr = addr == ADDR_W'(N_IN - 1);
  assign timed_out = tcnt == T_W'(TIMEOUT - 1);
  assign fin_ok    = bus.fc_finish && (state == DRAIN || state == WAIT_FIN);
  assign take      = res[idx] > best;
  assign cand      = take ? res[idx] : best;
  assign cand_idx  = take ? idx : best_idx;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  always_comb begin
    state_nxt       = state;
    rd              = 1'b0;
    bus.busy        = state != IDLE;
    bus.class_valid = state == DONE;
    case (state)
      IDLE:     state_nxt = bus.start ? FETCH : IDLE;
      FETCH: begin
        rd        = 1'b1;
        state_nxt = last_addr ? DRAIN : FETCH;
      end
      DRAIN:    state_nxt = fin_ok ? ARGMAX : WAIT_FIN;
      WAIT_FIN: state_nxt = fin_ok ? ARGMAX : timed_out ? IDLE : WAIT_FIN;
      ARGMAX:   state_nxt = idx == 4'd9 ? DONE : ARGMAX;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr     <= '0;
      tcnt     <= '0;
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      ena_q    <= 1'b0;
      err_q    <= 1'b0;
      id_q     <= '0;
      score_q  <= '0;
      for (int k = 0; k < 10; k++) res[k] <= '0;
    end else begin
      ena_q <= rd;
      tcnt  <= state == WAIT_FIN ? tcnt + 1'b1 : '0;
      if (state == IDLE && bus.start) begin
        addr  <= '0;
        err_q <= 1'b0;
      end
      if (state == FETCH) addr <= addr + 1'b1;
      if (state == WAIT_FIN && timed_out && !fin_ok) err_q <= 1'b1;
      if (fin_ok) begin
        for (int k = 0; k < 10; k++) res[k] <= bus.fc_dout[179 - 18*k -: 18];
        best     <= bus.fc_dout[179:162];
        best_idx <= '0;
        idx      <= 4'd1;
      end
      // The final comparison also loads the held outputs so they are valid in DONE.
      if (state == ARGMAX) begin
        best     <= cand;
        best_idx <= cand_idx;
        idx      <= idx + 1'b1;
        if (idx == 4'd9) begin
          id_q    <= cand_idx;
          score_q <= cand;
        end
      end
    end
  assign bus.buf_rd      = rd;
  assign bus.buf_addr    = rd ? addr : '0;
  assign bus.fc_ena      = ena_q;
  assign bus.fc_din      = bus.feat_data;
  assign bus.fc_weight   = bus.weight_data;
  assign bus.error       = err_q;
  assign bus.class_id    = id_q;
  assign bus.class_score = score_q;
endmodule

// File: tb/tb_fc_sequencer.sv
// tb_fc_sequencer: randomized directed passes checked against a cycle-level reference of the sequencer.
module tb_fc_sequencer;
  localparam int N_IN = 84, ADDR_W = 7, TIMEOUT = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  logic [3:0] last_id = '0;
  logic [15:0]  feat_mem [2**ADDR_W];
  logic [159:0] wt_mem   [2**ADDR_W];
  logic signed [17:0] r [10];
  fc_sequencer_if #(.ADDR_W(ADDR_W)) b();
  fc_sequencer #(.N_IN(N_IN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(b));
  always #5 clk = ~clk;
  // synchronous feature buffer / weight ROM
  always @(posedge clk)
    if (b.buf_rd) begin
      b.feat_data   <= feat_mem[b.buf_addr];
      b.weight_data <= wt_mem[b.buf_addr];
    end
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string nm);
    check({nm, "_busy0"}, 64'(b.busy), 0);
    check({nm, "_rd0"}, 64'(b.buf_rd), 0);
    check({nm, "_addr0"}, 64'(b.buf_addr), 0);
    check({nm, "_ena0"}, 64'(b.fc_ena), 0);
    check({nm, "_valid0"}, 64'(b.class_valid), 0);
    check({nm, "_err0"}, 64'(b.error), 0);
    check({nm, "_id0"}, 64'(b.class_id), 0);
    check({nm, "_score0"}, 64'(b.class_score), 0);
  endtask
  task automatic run_pass(input string nm, input int fin_rel, input int abort_addr, input bit glitch);
    int rel, exp_addr, ena_cnt, ena_first, ena_last, vcnt, vrel, brel, erel, exp_id;
    logic signed [17:0] exp_sc, got_sc, mx;
    logic [3:0] got_id;
    logic [179:0] dout;
    logic [191:0] junk;
    bit addr_ok, data_ok;
    mx = r[0];
    for (int k = 1; k < 10; k++) mx = r[k] > mx ? r[k] : mx;
    exp_sc = mx;
    exp_id = -1;
    for (int k = 0; k < 10; k++) if (exp_id < 0 && r[k] == mx) exp_id = k;
    for (int k = 0; k < 10; k++) dout[179 - 18*k -: 18] = r[k];
    exp_addr = 0; ena_cnt = 0; ena_first = -1; ena_last = -1; vcnt = 0; vrel = -1; brel = -1; erel = -1;
    addr_ok = 1; data_ok = 1; got_id = 'x; got_sc = 'x;
    b.start = 1'b1;
    step;
    b.start = 1'b0;
    check({nm, "_busy_rise"}, 64'(b.busy), 1);
    check({nm, "_err_clear"}, 64'(b.error), 0);
    for (rel = 1; rel < N_IN + 200; rel++) begin
      if (abort_addr >= 0 && b.buf_rd && int'(b.buf_addr) == abort_addr) begin
        reset = 1'b1;
        #1;
        check_zero({nm, "_async"});
        step;
        reset = 1'b0;
        step;
        last_id = '0;
        return;
      end
      if (b.buf_rd) begin
        if (int'(b.buf_addr) != exp_addr) addr_ok = 0;
        exp_addr++;
      end
      if (b.fc_ena) begin
        if (ena_first < 0) ena_first = rel;
        ena_last = rel;
        if (ena_cnt >= 2**ADDR_W || b.fc_din !== feat_mem[ena_cnt] || b.fc_weight !== wt_mem[ena_cnt]) data_ok = 0;
        ena_cnt++;
      end
      if (b.class_valid) begin
        vcnt++;
        vrel = rel;
        got_id = b.class_id;
        got_sc = b.class_score;
      end
      if (b.error && erel < 0) erel = rel;
      if (!b.busy) begin
        brel = rel;
        break;
      end
      junk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      b.fc_finish = rel == fin_rel || (glitch && (rel == 20 || rel == fin_rel + 4));
      b.fc_dout   = rel == fin_rel ? dout : junk[179:0];
      b.start     = glitch && (rel == 10 || rel == fin_rel + 3);
      step;
    end
    b.fc_finish = 1'b0;
    b.start = 1'b0;
    check({nm, "_addr_order"}, 64'(addr_ok), 1);
    check({nm, "_rd_count"}, exp_addr, N_IN);
    check({nm, "_ena_count"}, ena_cnt, N_IN);
    check({nm, "_ena_first"}, ena_first, 2);
    check({nm, "_ena_last"}, ena_last, N_IN + 1);
    check({nm, "_fc_data"}, 64'(data_ok), 1);
    if (fin_rel >= 0) begin
      check({nm, "_valid_count"}, vcnt, 1);
      check({nm, "_valid_cycle"}, vrel, fin_rel + 10);
      check({nm, "_busy_fall"}, brel, fin_rel + 11);
      check({nm, "_class_id"}, 64'(got_id), exp_id);
      check({nm, "_class_score"}, got_sc, exp_sc);
      check({nm, "_no_error"}, erel, -1);
      check({nm, "_id_held"}, 64'(b.class_id), exp_id);
      last_id = 4'(exp_id);
    end else begin
      check({nm, "_no_valid"}, vcnt, 0);
      check({nm, "_err_cycle"}, erel, N_IN + 2 + TIMEOUT);
      check({nm, "_busy_fall"}, brel, N_IN + 2 + TIMEOUT);
      check({nm, "_id_held"}, 64'(b.class_id), 64'(last_id));
    end
  endtask
  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) begin
      feat_mem[i] = 16'($urandom);
      wt_mem[i]   = {$urandom, $urandom, $urandom, $urandom, $urandom};
    end
    b.start = 1'b0;
    b.fc_finish = 1'b0;
    b.fc_dout = '0;
    #1;
    check_zero("reset");
    step;
    step;
    reset = 1'b0;
    step;
    r = '{18'sd5, -18'sd3, 18'sd200, 18'sd7, 18'sd200, 18'sd0, -18'sd1, 18'sd9, 18'sd10, 18'sd199};
    run_pass("basic", N_IN + 5, -1, 0);
    r = '{-18'sd10, -18'sd4, -18'sd4, -18'sd100, -18'sd20, -18'sd30, -18'sd40, -18'sd5, -18'sd60, -18'sd50};
    run_pass("neg", N_IN + 5, -1, 0);
    run_pass("tmo", -1, -1, 0);
    for (int k = 0; k < 10; k++) r[k] = 18'($urandom);
    run_pass("glitch", N_IN + 5, -1, 1);
    run_pass("abort", N_IN + 5, 40, 0);
    for (int k = 0; k < 10; k++) r[k] = 18'($urandom);
    run_pass("clean", N_IN + 8, -1, 0);
    for (int k = 0; k < 9; k++) begin
      r[k] = 18'($urandom);
      if (r[k] == 18'sd131071) r[k] = '0;
    end
    r[9] = 18'sd131071;
    run_pass("drain", N_IN + 1, -1, 0);
    run_pass("tmo2", -1, -1, 0);
    reset = 1'b1;
    #1;
    check("idle_reset_err", 64'(b.error), 0);
    step;
    reset = 1'b0;
    step;
    last_id = '0;
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 10; k++) r[k] = p[0] ? 18'($urandom) : 18'($urandom_range(0, 7)) - 18'd4;
      run_pass($sformatf("rand%0d", p), int'($urandom_range(N_IN + 1, N_IN + 30)), -1, 1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
